alu_seq: RTL and testbench

- Parametrised, handshaked successor of the datapath ALU.
- Keeps the existing 4-bit command encoding and adds iterative multiply, plus optional divide/remainder.
- Results are registered, with valid/ready flow control on both sides, so it can be placed in the EX stage behind a stall-capable pipeline.
- Flags illegal commands and zero results.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result, single-cycle logic/shift/add ops and a shift-add multiplier.
// Define ALU_SEQ_DIV_EN to add restoring unsigned divide (1100) and remainder (1101).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       execute_cammand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1011;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] CMD_DIVU = 4'b1100;
  localparam logic [3:0] CMD_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, result_reg;
  logic [CW-1:0]    cnt_reg;
  logic             zero_reg, illegal_reg;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_result;
  logic             op_illegal, op_iter;
  logic [WIDTH-1:0] step_a, step_b, step_acc, step_result;
  logic             last_step, accept;

`ifdef ALU_SEQ_DIV_EN
  logic             div_reg, rem_reg;
  logic             op_div;
  logic [WIDTH:0]   div_shifted;
`endif

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_step = (cnt_reg == CW'(1));

  // Command decode and single-cycle datapath, evaluated on the live inputs at accept.
  always_comb begin
    shamt      = data2[SHW-1:0];
    op_result  = '0;
    op_illegal = 1'b0;
    op_iter    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    op_div     = 1'b0;
`endif
    case (execute_cammand)
      CMD_ADD: op_result = data1 + data2;
      CMD_SUB: op_result = data1 - data2;
      CMD_AND: op_result = data1 & data2;
      CMD_OR:  op_result = data1 | data2;
      CMD_NOR: op_result = ~(data1 | data2);
      CMD_XOR: op_result = data1 ^ data2;
      CMD_SLL: op_result = data1 << shamt;
      CMD_SRA: op_result = $signed(data1) >>> shamt;
      CMD_SRL: op_result = data1 >> shamt;
      CMD_MUL: op_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      // A zero divisor short-circuits to a single-cycle result.
      CMD_DIVU: begin
        if (data2 == '0) begin
          op_result = '1;
        end else begin
          op_iter = 1'b1;
          op_div  = 1'b1;
        end
      end
      CMD_REMU: begin
        if (data2 == '0) begin
          op_result = data1;
        end else begin
          op_iter = 1'b1;
          op_div  = 1'b1;
        end
      end
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  // One iteration of the multiplier (or divider) per BUSY cycle.
  always_comb begin
    step_a      = a_reg << 1;
    step_b      = b_reg >> 1;
    step_acc    = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    step_result = step_acc;
`ifdef ALU_SEQ_DIV_EN
    div_shifted = {acc_reg, b_reg[WIDTH-1]};
    if (div_reg) begin
      step_a = a_reg;
      // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
      if (div_shifted >= {1'b0, a_reg}) begin
        step_acc = div_shifted[WIDTH-1:0] - a_reg;
        step_b   = {b_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shifted[WIDTH-1:0];
        step_b   = {b_reg[WIDTH-2:0], 1'b0};
      end
      step_result = rem_reg ? step_acc : step_b;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = op_iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_reg     <= 1'b0;
      rem_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (op_iter) begin
          a_reg   <= data1;
          b_reg   <= data2;
          acc_reg <= '0;
          cnt_reg <= CW'(WIDTH);
`ifdef ALU_SEQ_DIV_EN
          div_reg <= op_div;
          rem_reg <= (execute_cammand == CMD_REMU);
          // Divider keeps the divisor in a_reg and shifts the dividend out of b_reg.
          if (op_div) begin
            a_reg <= data2;
            b_reg <= data1;
          end
`endif
        end else begin
          result_reg  <= op_result;
          zero_reg    <= (op_result == '0);
          illegal_reg <= op_illegal;
        end
      end else if (state_reg == BUSY) begin
        a_reg   <= step_a;
        b_reg   <= step_b;
        acc_reg <= step_acc;
        cnt_reg <= cnt_reg - CW'(1);
        if (last_step) begin
          result_reg  <= step_result;
          zero_reg    <= (step_result == '0);
          illegal_reg <= 1'b0;
        end
      end
    end
  end

  assign result  = result_reg;
  assign zero    = zero_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus randomized traffic against a behavioural model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [3:0]  cmd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data1(data1),
    .data2(data2),
    .execute_cammand(cmd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an operation must produce and how many cycles until out_valid.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    int unsigned sh;
    sh  = b[4:0];
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (c)
      4'h0: r = a + b;
      4'h2: r = a - b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = ~(a | b);
      4'h7: r = a ^ b;
      4'h8: r = a << sh;
      4'h9: r = $signed(a) >>> sh;
      4'hA: r = a >> sh;
      4'hB: begin
        p   = {32'b0, a} * {32'b0, b};
        r   = p[31:0];
        lat = 33;
      end
`ifdef ALU_SEQ_DIV_EN
      4'hC: begin
        if (b == 0) r = '1;
        else begin r = a / b; lat = 33; end
      end
      4'hD: begin
        if (b == 0) r = a;
        else begin r = a % b; lat = 33; end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Cycle-level model state, advanced once per rising edge.
  logic        m_pending = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_show = 1'b1;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;
  logic        m_ill = 1'b0;
  logic [31:0] m_exp_res = '0;
  logic        m_exp_ill = 1'b0;

  always @(posedge clk) begin : compare
    logic        s_v, s_or, s_rst;
    logic [3:0]  s_c;
    logic [31:0] s_a, s_b;
    int          lat;
    s_v   = in_valid;
    s_or  = out_ready;
    s_rst = rst;
    s_c   = cmd;
    s_a   = data1;
    s_b   = data2;
    #1;
    if (!s_rst) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
      m_show    = 1'b1;
      m_res     = '0;
      m_zero    = 1'b0;
      m_ill     = 1'b0;
    end else if (m_valid) begin
      if (s_or) begin
        m_valid   = 1'b0;
        m_pending = 1'b0;
        m_show    = 1'b0;
      end
    end else if (m_pending) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_res   = m_exp_res;
        m_zero  = (m_exp_res == 0);
        m_ill   = m_exp_ill;
      end
    end else if (s_v) begin
      model(s_c, s_a, s_b, m_exp_res, m_exp_ill, lat);
      m_pending = 1'b1;
      m_show    = 1'b0;
      m_wait    = lat - 1;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_res   = m_exp_res;
        m_zero  = (m_exp_res == 0);
        m_ill   = m_exp_ill;
      end
    end
    chk1("cyc in_ready", in_ready, !m_pending);
    chk1("cyc out_valid", out_valid, m_valid);
    if (m_valid || m_show) begin
      chk32("cyc result", result, m_res);
      chk1("cyc zero", zero, m_zero);
      chk1("cyc illegal", illegal, m_ill);
    end
  end

  // Directed operation with literal expectations; stall = cycles out_ready is held low once valid.
  task automatic op(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_r, input logic exp_ill, input int exp_lat, input int stall);
    logic [31:0] mr;
    logic        mi;
    int          ml;
    int          n;
    model(c, a, b, mr, mi, ml);
    chk32({name, " model result"}, mr, exp_r);
    chk32({name, " model latency"}, ml, exp_lat);
    @(negedge clk);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    cmd       = c;
    data1     = a;
    data2     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk1({name, " accept timeout"}, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cmd      = 4'($urandom);
    data1    = $urandom;
    data2    = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      chk1({name, " busy in_ready"}, in_ready, 1'b0);
      @(negedge clk);
      n++;
    end
    chk32({name, " latency"}, n, exp_lat);
    chk32({name, " result"}, result, exp_r);
    chk1({name, " zero"}, zero, exp_r == 0);
    chk1({name, " illegal"}, illegal, exp_ill);
    for (int i = 1; i < stall; i++) begin
      @(negedge clk);
      chk1({name, " held out_valid"}, out_valid, 1'b1);
      chk32({name, " held result"}, result, exp_r);
      chk1({name, " held in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1({name, " drained out_valid"}, out_valid, 1'b0);
    chk1({name, " drained in_ready"}, in_ready, 1'b1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset in_ready", in_ready, 1'b1);
    chk32("reset result", result, 32'h0);
    chk1("reset zero", zero, 1'b0);
    chk1("reset illegal", illegal, 1'b0);
    rst = 1'b1;

    op("add wrap", 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1, 0);
    op("sub zero", 4'h2, 32'd5, 32'd5, 32'h0, 1'b0, 1, 0);
    op("sra", 4'h9, 32'hF000_0000, 32'h24, 32'hFF00_0000, 1'b0, 1, 0);
    op("srl", 4'hA, 32'hF000_0000, 32'h24, 32'h0F00_0000, 1'b0, 1, 0);
    op("sll", 4'h8, 32'h0000_0081, 32'hFFFF_FFE3, 32'h0000_0408, 1'b0, 1, 0);
    op("nor", 4'h6, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1, 0);
    op("mul", 4'hB, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 33, 0);
    op("mul small", 4'hB, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33, 0);
    op("add backpressure", 4'h0, 32'd3, 32'd4, 32'd7, 1'b0, 1, 5);
    op("illegal 1111", 4'hF, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 1, 0);
`ifdef ALU_SEQ_DIV_EN
    op("divu", 4'hC, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0);
    op("remu", 4'hD, 32'd100, 32'd7, 32'd2, 1'b0, 33, 0);
    op("divu by zero", 4'hC, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    op("remu by zero", 4'hD, 32'h1234, 32'h0, 32'h1234, 1'b0, 1, 0);
`else
    op("cmd 1100 illegal", 4'hC, 32'd100, 32'd7, 32'h0, 1'b1, 1, 0);
`endif
    op("add before abort", 4'h0, 32'd20, 32'd22, 32'd42, 1'b0, 1, 0);

    // Abort a multiply ten cycles into BUSY.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cmd       = 4'hB;
    data1     = 32'h0000_1234;
    data2     = 32'h0000_5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk1("mid-mul busy", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("abort out_valid", out_valid, 1'b0);
    chk1("abort in_ready", in_ready, 1'b1);
    chk32("abort result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    op("add after abort", 4'h0, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);

    // Randomized traffic: the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      cmd       = 4'($urandom_range(0, 15));
      data1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       data2 = 32'h0;
        1, 2:    data2 = 32'($urandom_range(1, 100));
        default: data2 = $urandom;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
